// File: rtl/keypoint_scan_ctrl_if.sv
// Bundle between the keypoint row sequencer and its detectors, filters and keypoint SRAMs.
// The master side is the surrounding datapath. The slave side is the controller.
interface keypoint_scan_ctrl_if #(
  parameter int unsigned NUM_SCALES = 2,
  parameter int unsigned COLS       = 638,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned KP_AW      = 11
);
  logic                                   start;
  logic                                   busy;
  logic                                   done;
  logic [ROW_W-1:0]                       row_addr;
  logic                                   buffer_we;
  logic [NUM_SCALES*COLS-1:0]             is_keypoint;
  logic [NUM_SCALES-1:0]                  cand_valid;
  logic [NUM_SCALES*COL_W-1:0]            cand_col;
  logic [NUM_SCALES-1:0]                  filt_pass;
  logic [NUM_SCALES-1:0]                  kp_we;
  logic [NUM_SCALES*KP_AW-1:0]            kp_addr;
  logic [NUM_SCALES*(ROW_W+COL_W)-1:0]    kp_din;
  logic [NUM_SCALES*(KP_AW+1)-1:0]        kp_count;
  logic [NUM_SCALES-1:0]                  kp_overflow;

  modport master (
    output start, is_keypoint, filt_pass,
    input  busy, done, row_addr, buffer_we, cand_valid, cand_col,
           kp_we, kp_addr, kp_din, kp_count, kp_overflow
  );

  modport slave (
    input  start, is_keypoint, filt_pass,
    output busy, done, row_addr, buffer_we, cand_valid, cand_col,
           kp_we, kp_addr, kp_din, kp_count, kp_overflow
  );
endinterface

// File: rtl/keypoint_scan_ctrl.sv
// Row sequencer for NUM_SCALES DoG detectors. Each set candidate bit is drained one per cycle
// per scale through an external filter. Each passing {row,col} is written to that scale's keypoint SRAM.
module keypoint_scan_ctrl #(
  parameter int unsigned NUM_SCALES = 2,
  parameter int unsigned COLS       = 638,
  parameter int unsigned ROWS       = 480,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned KP_AW      = 11,
  parameter int unsigned READY_CYC  = 2,
  parameter int unsigned PRIME_ROWS = 2,
  parameter int unsigned ROW_OFS    = 1,
  parameter int unsigned COL_OFS    = 1
) (
  input  logic                clk,
  input  logic                rst,
  keypoint_scan_ctrl_if.slave bus
);
  localparam int unsigned CycW = (READY_CYC > 1) ? $clog2(READY_CYC) : 1;
  localparam int unsigned KpW  = ROW_W + COL_W;

  typedef enum logic [2:0] {
    StIdle, StReady, StDetect, StFilter, StUpdate, StBuffer, StDone
  } state_e;

  state_e                             r_state, w_state_nxt;
  logic [ROW_W-1:0]                   r_row;
  logic [CycW-1:0]                    r_cyc;
  logic [NUM_SCALES-1:0][COLS-1:0]    r_mask, w_mask_load, w_mask_clr;
  logic [NUM_SCALES-1:0]              r_kp_we;
  logic [NUM_SCALES-1:0][KP_AW-1:0]   r_kp_addr;
  logic [NUM_SCALES-1:0][KpW-1:0]     r_kp_din;
  logic [NUM_SCALES-1:0][KP_AW:0]     r_kp_count;
  logic [NUM_SCALES-1:0]              r_kp_ovf;
  logic [NUM_SCALES-1:0]              w_cand_valid, w_hit;
  logic [NUM_SCALES-1:0][COL_W-1:0]   w_cand_col;
  logic                               w_start_acc, w_priming, w_ready_last;
  logic                               w_load_zero, w_clr_zero, w_last_row;

  always_comb begin
    w_start_acc  = (r_state == StIdle) && bus.start && !rst;
    w_priming    = r_row < ROW_W'(PRIME_ROWS);
    w_ready_last = r_cyc == CycW'(READY_CYC - 1);
    w_last_row   = r_row == ROW_W'(ROWS - 1);
    w_mask_load  = '0;
    w_mask_clr   = '0;
    w_cand_valid = '0;
    w_cand_col   = '0;
    w_hit        = '0;
    for (int s = 0; s < NUM_SCALES; s++) begin
      w_mask_load[s]  = w_priming ? '0 : bus.is_keypoint[s*COLS +: COLS];
      // x & (x-1) drops the lowest set bit, i.e. the candidate being presented now
      w_mask_clr[s]   = r_mask[s] & (r_mask[s] - COLS'(1));
      w_cand_valid[s] = (r_state == StFilter) && (r_mask[s] != '0);
      for (int i = COLS - 1; i >= 0; i--) begin
        if (r_mask[s][i]) w_cand_col[s] = COL_W'(i);
      end
      w_hit[s] = w_cand_valid[s] && bus.filt_pass[s];
    end
    w_load_zero = (w_mask_load == '0);
    w_clr_zero  = (w_mask_clr == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (bus.start) w_state_nxt = StReady;
      StReady:  if (w_ready_last) w_state_nxt = StDetect;
      StDetect: w_state_nxt = w_load_zero ? StUpdate : StFilter;
      StFilter: if (w_clr_zero) w_state_nxt = StUpdate;
      StUpdate: w_state_nxt = w_last_row ? StDone : StBuffer;
      StBuffer: w_state_nxt = StReady;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_row      <= '0;
      r_cyc      <= '0;
      r_mask     <= '0;
      r_kp_we    <= '0;
      r_kp_addr  <= '0;
      r_kp_din   <= '0;
      r_kp_count <= '0;
      r_kp_ovf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_kp_we <= '0;
      if (w_start_acc) begin
        r_row      <= '0;
        r_kp_addr  <= '0;
        r_kp_count <= '0;
        r_kp_ovf   <= '0;
      end
      if (r_state == StReady) r_cyc <= w_ready_last ? '0 : r_cyc + CycW'(1);
      if (r_state == StDetect) r_mask <= w_mask_load;
      if (r_state == StFilter) r_mask <= w_mask_clr;
      if (r_state == StUpdate && !w_last_row) r_row <= r_row + ROW_W'(1);
      if (r_state == StDone) r_row <= '0;
      for (int s = 0; s < NUM_SCALES; s++) begin
        if (w_hit[s]) begin
          // count MSB set means the SRAM already holds 2**KP_AW entries
          if (!r_kp_count[s][KP_AW]) begin
            r_kp_we[s]    <= 1'b1;
            r_kp_addr[s]  <= r_kp_count[s][KP_AW-1:0];
            r_kp_count[s] <= r_kp_count[s] + (KP_AW+1)'(1);
            r_kp_din[s]   <= {r_row - ROW_W'(ROW_OFS), w_cand_col[s] + COL_W'(COL_OFS)};
          end else begin
            r_kp_ovf[s] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.busy        = (r_state != StIdle);
    bus.done        = (r_state == StDone) && !rst;
    bus.buffer_we   = w_start_acc || ((r_state == StBuffer) && !rst);
    bus.row_addr    = r_row;
    bus.cand_valid  = w_cand_valid;
    bus.cand_col    = w_cand_col;
    bus.kp_we       = r_kp_we;
    bus.kp_addr     = r_kp_addr;
    bus.kp_din      = r_kp_din;
    bus.kp_count    = r_kp_count;
    bus.kp_overflow = r_kp_ovf;
  end
endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Bench for keypoint_scan_ctrl. Frame tables of candidate and pass bits drive the DUT.
// A whole-frame model predicts the writes, counts, overflow and frame length.
module tb_keypoint_scan_ctrl;
  localparam int unsigned NS    = 2;
  localparam int unsigned COLS  = 16;
  localparam int unsigned ROWS  = 8;
  localparam int unsigned ROW_W = 3;
  localparam int unsigned COL_W = 5;
  localparam int unsigned KP_AW = 2;
  localparam int unsigned RDY   = 2;
  localparam int unsigned PRIME = 2;
  localparam int unsigned DW    = ROW_W + COL_W;
  localparam int unsigned EW    = KP_AW + DW;
  localparam int unsigned DEPTH = 1 << KP_AW;

  logic clk, rst;
  keypoint_scan_ctrl_if #(.NUM_SCALES(NS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
                          .KP_AW(KP_AW)) bus ();

  keypoint_scan_ctrl #(
    .NUM_SCALES(NS), .COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .COL_W(COL_W), .KP_AW(KP_AW),
    .READY_CYC(RDY), .PRIME_ROWS(PRIME), .ROW_OFS(1), .COL_OFS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [COLS-1:0] kp_tbl   [NS][ROWS];
  logic [COLS-1:0] pass_tbl [NS][ROWS];

  logic [EW-1:0] exp_q [NS][$];
  int exp_count [NS];
  int exp_ovf   [NS];
  int exp_cand  [NS];
  int exp_cycles;

  int n_pass = 0, n_tot = 0;
  int cyc = 0;
  int s_cyc, done_cyc, done_seen, bwe_seen;
  int cand_seen [NS];
  bit mon_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: detector outputs follow row_addr, filter verdict comes from the pass table
  always_comb begin
    bus.is_keypoint = '0;
    bus.filt_pass   = '0;
    for (int s = 0; s < NS; s++) begin
      bus.is_keypoint[s*COLS +: COLS] = kp_tbl[s][bus.row_addr];
      bus.filt_pass[s] = pass_tbl[s][bus.row_addr][bus.cand_col[s*COL_W +: 4]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (mon_en) begin
      if (bus.buffer_we) bwe_seen++;
      for (int s = 0; s < NS; s++) begin
        if (bus.cand_valid[s]) cand_seen[s]++;
        if (bus.kp_we[s]) begin
          if (exp_q[s].size() == 0) chk("kp_write_extra", 64'(bus.kp_we[s]), 0);
          else chk("kp_write", {bus.kp_addr[s*KP_AW +: KP_AW], bus.kp_din[s*DW +: DW]},
                   exp_q[s].pop_front());
        end
      end
    end
  end

  task automatic clear_tbl();
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < ROWS; r++) begin
        kp_tbl[s][r]   = '0;
        pass_tbl[s][r] = '1;
      end
  endtask

  // Whole-frame prediction: scan rows and columns in order, cap writes at the SRAM depth
  task automatic build_model();
    int kmax, n;
    exp_cycles = 1 + (ROWS - 1) + 1;
    for (int s = 0; s < NS; s++) begin
      exp_q[s].delete();
      exp_count[s] = 0;
      exp_ovf[s]   = 0;
      exp_cand[s]  = 0;
    end
    for (int r = 0; r < ROWS; r++) begin
      kmax = 0;
      if (r >= int'(PRIME)) begin
        for (int s = 0; s < NS; s++) begin
          n = $countones(kp_tbl[s][r]);
          exp_cand[s] += n;
          if (n > kmax) kmax = n;
          for (int c = 0; c < int'(COLS); c++) begin
            if (kp_tbl[s][r][c] && pass_tbl[s][r][c]) begin
              if (exp_count[s] < int'(DEPTH)) begin
                exp_q[s].push_back({KP_AW'(exp_count[s]), ROW_W'(r - 1), COL_W'(c + 1)});
                exp_count[s]++;
              end else begin
                exp_ovf[s] = 1;
              end
            end
          end
        end
      end
      exp_cycles += int'(RDY) + 1 + kmax + 1;
    end
  endtask

  task automatic run_frame(input string tag);
    build_model();
    for (int s = 0; s < NS; s++) cand_seen[s] = 0;
    bwe_seen  = 0;
    done_seen = 0;
    done_cyc  = 0;
    mon_en    = 1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, 64'(bus.busy), 1);
    chk({tag, "_start_cnt"}, 64'(bus.kp_count), 0);
    chk({tag, "_start_ovf"}, 64'(bus.kp_overflow), 0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (done_seen != 0) break;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, 64'(done_seen), 1);
    chk({tag, "_frame_len"}, 64'(done_cyc - s_cyc + 1), 64'(exp_cycles));
    chk({tag, "_buffer_we"}, 64'(bwe_seen), 64'(ROWS));
    chk({tag, "_busy_end"}, 64'(bus.busy), 0);
    for (int s = 0; s < NS; s++) begin
      chk({tag, "_count"}, 64'(bus.kp_count[s*(KP_AW+1) +: KP_AW+1]), 64'(exp_count[s]));
      chk({tag, "_ovf"}, 64'(bus.kp_overflow[s]), 64'(exp_ovf[s]));
      chk({tag, "_missing_wr"}, 64'(exp_q[s].size()), 0);
      chk({tag, "_cand_cyc"}, 64'(cand_seen[s]), 64'(exp_cand[s]));
    end
    mon_en = 0;
  endtask

  initial begin
    bit found;
    bus.start = 1'b0;
    rst = 1'b1;
    clear_tbl();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_kp_we", 64'(bus.kp_we), 0);
    chk("rst_row", 64'(bus.row_addr), 0);
    chk("rst_count", 64'(bus.kp_count), 0);
    chk("rst_ovf", 64'(bus.kp_overflow), 0);
    chk("rst_cand", 64'(bus.cand_valid), 0);
    chk("rst_bwe", 64'(bus.buffer_we), 0);

    run_frame("zero");
    chk("pin_zero_len", 64'(exp_cycles), 41);

    clear_tbl();
    kp_tbl[0][3] = 16'h0204;
    build_model();
    chk("pin_r3_w0", 64'(exp_q[0][0]), 64'({2'd0, 3'd2, 5'd3}));
    chk("pin_r3_w1", 64'(exp_q[0][1]), 64'({2'd1, 3'd2, 5'd10}));
    run_frame("row3");

    clear_tbl();
    kp_tbl[0][2] = 16'h00A1;
    kp_tbl[1][2] = 16'h0010;
    pass_tbl[0][2] = 16'h0020;
    pass_tbl[1][2] = 16'h0000;
    build_model();
    chk("pin_r2_w0", 64'(exp_q[0][0]), 64'({2'd0, 3'd1, 5'd6}));
    chk("pin_r2_len", 64'(exp_cycles), 44);
    run_frame("row2");

    clear_tbl();
    for (int s = 0; s < NS; s++) begin
      kp_tbl[s][0] = '1;
      kp_tbl[s][1] = '1;
    end
    build_model();
    chk("pin_prime_cand", 64'(exp_cand[0]), 0);
    run_frame("prime");

    clear_tbl();
    kp_tbl[1][4] = 16'h003F;
    build_model();
    chk("pin_ovf_cnt", 64'(exp_count[1]), 4);
    chk("pin_ovf_flag", 64'(exp_ovf[1]), 1);
    run_frame("ovf");
    clear_tbl();
    run_frame("after_ovf");

    // Abort a frame while candidates are being drained
    clear_tbl();
    kp_tbl[0][3] = '1;
    done_seen = 0;
    found = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.cand_valid != 0) begin
        found = 1;
        break;
      end
    end
    chk("mid_reach_filter", 64'(found), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", 64'(bus.busy), 0);
    chk("mid_kp_we", 64'(bus.kp_we), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_done", 64'(done_seen), 0);
    chk("mid_idle", 64'(bus.busy), 0);
    clear_tbl();
    run_frame("post_rst");

    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < NS; s++)
        for (int r = 0; r < ROWS; r++) begin
          kp_tbl[s][r]   = COLS'($urandom & $urandom & $urandom);
          pass_tbl[s][r] = COLS'($urandom);
        end
      run_frame("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
